// File: rtl/scan_capture_if.sv
// Purpose : bundles the scan observation inputs and the frame handshake of scan_capture.
// Ports   : en/row/column carry the observed scan; frame/frame_changed/scan_err are
//           qualified by frame_valid and consumed with frame_ready.
// master  = capture block (frame producer), slave = frame consumer / scan source.
interface scan_capture_if;
  logic        en;
  logic [4:0]  row;
  logic [6:0]  column;
  logic [34:0] frame;
  logic        frame_valid;
  logic        frame_ready;
  logic        frame_changed;
  logic        scan_err;

  modport master (
    input  en,
    input  row,
    input  column,
    input  frame_ready,
    output frame,
    output frame_valid,
    output frame_changed,
    output scan_err
  );

  modport slave (
    output en,
    output row,
    output column,
    output frame_ready,
    input  frame,
    input  frame_valid,
    input  frame_changed,
    input  scan_err
  );
endinterface

// File: rtl/scan_capture.sv
// Purpose : accumulates a 5x7 multiplexed LED scan over WINDOW clocks into a 35-bit picture.
// Latency : frame_valid rises WINDOW clocks after capture starts; one frame per WINDOW+1 clocks.
// Backpr. : frame held stable in HOLD until frame_ready; scan input is ignored while held.
// Ports   : CLOCK_50 (rising edge), rst_n (synchronous, active low),
//           bus (master): en/row/column in, frame/frame_valid/frame_changed/scan_err out,
//           frame_ready in. Frame bit r*7+c is pixel (row r, column c).
// WINDOW must lie in 5..255 so the final sample index fits the 8-bit count.
module scan_capture #(
  parameter int unsigned WINDOW = 35
) (
  input  logic           CLOCK_50,
  input  logic           rst_n,
  scan_capture_if.master bus
);

  localparam logic [7:0] LAST_IDX = 8'(WINDOW - 1);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    HOLD
  } state_t;

  state_t      state;
  logic [34:0] acc;
  logic [7:0]  count;
  logic        err_flag;
  logic [34:0] frame_q;
  logic [34:0] prev_frame;
  logic        frame_valid_q;
  logic        frame_changed_q;
  logic        scan_err_q;

  // Per-sample contribution: only a strictly one-hot row deposits its column bits.
  logic        row_onehot;
  logic        row_multi;
  logic [34:0] sample_bits;
  logic [34:0] acc_next;
  logic        err_next;

  always_comb begin
    row_onehot  = (bus.row != 5'd0) && ((bus.row & (bus.row - 5'd1)) == 5'd0);
    row_multi   = (bus.row != 5'd0) && !row_onehot;
    sample_bits = '0;
    if (row_onehot) begin
      for (int r = 0; r < 5; r++) begin
        if (bus.row[r]) begin
          sample_bits[r*7 +: 7] = bus.column;
        end
      end
    end
    // These include the current sample so the closing sample lands in the frame.
    acc_next = acc | sample_bits;
    err_next = err_flag | row_multi;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state           <= IDLE;
      acc             <= '0;
      count           <= '0;
      err_flag        <= 1'b0;
      frame_q         <= '0;
      prev_frame      <= '0;
      frame_valid_q   <= 1'b0;
      frame_changed_q <= 1'b0;
      scan_err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.en) begin
            state    <= CAPTURE;
            acc      <= '0;
            count    <= '0;
            err_flag <= 1'b0;
          end
        end

        CAPTURE: begin
          if (!bus.en) begin
            // Abort: partial picture is dropped, last delivered frame untouched.
            state    <= IDLE;
            acc      <= '0;
            count    <= '0;
            err_flag <= 1'b0;
          end else if (count == LAST_IDX) begin
            frame_q         <= acc_next;
            scan_err_q      <= err_next;
            frame_changed_q <= (acc_next != prev_frame);
            frame_valid_q   <= 1'b1;
            state           <= HOLD;
            // Count returns to zero instead of passing LAST_IDX.
            count           <= '0;
          end else begin
            acc      <= acc_next;
            err_flag <= err_next;
            count    <= count + 8'd1;
          end
        end

        HOLD: begin
          // en is deliberately not looked at until the consumer takes the frame.
          if (frame_valid_q && bus.frame_ready) begin
            frame_valid_q <= 1'b0;
            prev_frame    <= frame_q;
            acc           <= '0;
            count         <= '0;
            err_flag      <= 1'b0;
            state         <= bus.en ? CAPTURE : IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.frame         = frame_q;
  assign bus.frame_valid   = frame_valid_q;
  assign bus.frame_changed = frame_changed_q;
  assign bus.scan_err      = scan_err_q;

endmodule

// File: tb/tb_scan_capture.sv
// Purpose : directed scenarios for scan_capture with a queue of expected frames.
// Ports   : drives CLOCK_50, rst_n and the slave side of scan_capture_if.
// A negedge monitor pops an expectation when a frame appears and checks it every held cycle.
module tb_scan_capture;
  localparam int W = 35;

  localparam logic [34:0] CB   = 35'h2AAAAAAAA;
  localparam logic [34:0] ONES = 35'h7FFFFFFFF;
  localparam logic [34:0] ALT  = 35'h155555555;

  logic CLOCK_50 = 1'b0;
  logic rst_n;

  always #10 CLOCK_50 = ~CLOCK_50;

  scan_capture_if bus ();

  scan_capture #(.WINDOW(W)) dut (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .bus      (bus.master)
  );

  typedef struct packed {
    logic [34:0] frame;
    logic        changed;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  bit          have_cur = 1'b0;
  bit          holding  = 1'b0;
  int          errors   = 0;
  int          checks   = 0;
  logic [34:0] model_prev;

  task automatic chk_vec(input string name, input logic [34:0] act, input logic [34:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Row-major per-pixel scan: sample i shows pixel i only (lit or dark).
  task automatic drive_sample(input int i, input logic [34:0] p, input int err_idx, input bit blank);
    if (blank) begin
      bus.row    = 5'd0;
      bus.column = 7'd0;
    end else if (i == err_idx) begin
      bus.row    = 5'b00011;
      bus.column = 7'h7F;
    end else begin
      bus.row    = 5'(1 << (i / 7));
      bus.column = p[i] ? 7'(1 << (i % 7)) : 7'd0;
    end
  endtask

  // Optional entry clock (IDLE->CAPTURE or handshake), then WINDOW samples.
  task automatic run_window(input string name, input bit lead, input logic [34:0] p,
                            input int err_idx, input bit blank, input bit ready_during);
    exp_t e;
    e.frame = blank ? 35'd0 : p;
    if (!blank && err_idx >= 0) e.frame[err_idx] = 1'b0;
    e.err     = (!blank && err_idx >= 0);
    e.changed = (e.frame != model_prev);
    model_prev = e.frame;
    exp_q.push_back(e);
    if (lead) begin
      bus.row    = 5'd0;
      bus.column = 7'd0;
      step();
    end
    bus.frame_ready = ready_during;
    for (int i = 0; i < W; i++) begin
      drive_sample(i, p, err_idx, blank);
      step();
      if (i == W - 2) chk_bit({name, "_not_early"}, bus.frame_valid, 1'b0);
    end
    chk_bit({name, "_latency"}, bus.frame_valid, 1'b1);
  endtask

  task automatic partial_window(input int n, input logic [34:0] p);
    bus.row    = 5'd0;
    bus.column = 7'd0;
    step();
    for (int i = 0; i < n; i++) begin
      drive_sample(i, p, -1, 1'b0);
      step();
    end
    chk_bit("partial_no_valid", bus.frame_valid, 1'b0);
  endtask

  // Scoreboard monitor
  always @(negedge CLOCK_50) begin
    if (bus.frame_valid === 1'b1) begin
      if (!holding) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          have_cur = 1'b0;
          $display("FAIL mon_unexpected_frame: got frame %h expected no frame", bus.frame);
        end else begin
          cur      = exp_q.pop_front();
          have_cur = 1'b1;
        end
      end
      if (have_cur) begin
        chk_vec("mon_frame", bus.frame, cur.frame);
        chk_bit("mon_changed", bus.frame_changed, cur.changed);
        chk_bit("mon_scan_err", bus.scan_err, cur.err);
      end
      holding = (bus.frame_ready !== 1'b1);
    end else begin
      holding = 1'b0;
    end
  end

  initial begin
    rst_n           = 1'b0;
    bus.en          = 1'b0;
    bus.row         = 5'd0;
    bus.column      = 7'd0;
    bus.frame_ready = 1'b0;
    model_prev      = '0;
    step();
    step();
    chk_vec("rst_frame", bus.frame, 35'd0);
    chk_bit("rst_valid", bus.frame_valid, 1'b0);
    chk_bit("rst_changed", bus.frame_changed, 1'b0);
    chk_bit("rst_scan_err", bus.scan_err, 1'b0);

    // Continuous capture: identical second checkerboard must not flag a change.
    rst_n           = 1'b1;
    bus.en          = 1'b1;
    bus.frame_ready = 1'b1;
    run_window("cb1", 1'b1, CB, -1, 1'b0, 1'b1);
    run_window("cb2", 1'b1, CB, -1, 1'b0, 1'b1);
    run_window("ones", 1'b1, ONES, -1, 1'b0, 1'b1);
    run_window("blank", 1'b1, '0, -1, 1'b1, 1'b1);
    run_window("rowerr", 1'b1, CB, 10, 1'b0, 1'b1);

    // Backpressure: 20 held clocks with moving scan input, handshake on the 21st.
    run_window("bp", 1'b1, ONES, -1, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      bus.row    = 5'($urandom);
      bus.column = 7'($urandom);
      step();
      chk_bit("bp_hold", bus.frame_valid, 1'b1);
    end
    bus.frame_ready = 1'b1;
    step();
    chk_bit("bp_drop", bus.frame_valid, 1'b0);
    run_window("bp_restart", 1'b0, CB, -1, 1'b0, 1'b1);

    // en drop on count 17 of a window of all-ones.
    partial_window(17, ONES);
    bus.en = 1'b0;
    drive_sample(17, ONES, -1, 1'b0);
    step();
    for (int k = 0; k < 40; k++) begin
      step();
      chk_bit("abort_no_valid", bus.frame_valid, 1'b0);
    end
    bus.en = 1'b1;
    run_window("after_abort", 1'b1, ALT, -1, 1'b0, 1'b0);

    // en drop during HOLD: frame stays until taken, then the block idles.
    bus.en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_bit("hold_en0_valid", bus.frame_valid, 1'b1);
    end
    bus.frame_ready = 1'b1;
    step();
    chk_bit("hold_en0_drop", bus.frame_valid, 1'b0);
    for (int k = 0; k < 40; k++) begin
      step();
      chk_bit("hold_en0_idle", bus.frame_valid, 1'b0);
    end

    // Reset at count 30, then a full fresh window with an error on the last sample.
    bus.en = 1'b1;
    partial_window(30, ONES);
    rst_n = 1'b0;
    drive_sample(30, ONES, -1, 1'b0);
    step();
    model_prev = '0;
    chk_vec("midrst_frame", bus.frame, 35'd0);
    chk_bit("midrst_valid", bus.frame_valid, 1'b0);
    chk_bit("midrst_changed", bus.frame_changed, 1'b0);
    chk_bit("midrst_scan_err", bus.scan_err, 1'b0);
    rst_n = 1'b1;
    run_window("post_reset", 1'b1, CB, 34, 1'b0, 1'b1);

    bus.en = 1'b0;
    bus.row = 5'd0;
    bus.column = 7'd0;
    repeat (4) step();
    chk_vec("queue_empty", 35'(exp_q.size()), 35'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
